key_extend: RTL
===============

KEY_EXTEND -- requirements
Module: key_extend

Interface
REQ-001 SHALL have parameter W, default 20, giving the input candidate width; legal range 20..47.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port CAND_IN, input, W bits: partial-state candidate from the upstream enumerator or the previous extend stage.
REQ-005 SHALL have port IN_LAST, input, 1 bit: marks the final candidate of a batch.
REQ-006 SHALL have port KS_BIT, input, 1 bit: the keystream bit the extended candidate must reproduce.
REQ-007 SHALL have port IN_VALID, input, 1 bit, and port IN_READY, output, 1 bit: valid/ready handshake for candidates.
REQ-008 SHALL have port CAND_OUT, output, W+1 bits: surviving extended candidate.
REQ-009 SHALL have port OUT_VALID, output, 1 bit, and port OUT_READY, input, 1 bit: valid/ready handshake for survivors.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle pulse when a batch is fully processed.
REQ-011 SHALL have port SURV_CNT, output, 16 bits: survivors emitted since reset.

Function
REQ-012 SHALL perform a transfer on any edge where VALID and READY are both 1; no other condition SHALL constitute a transfer.
REQ-013 SHALL define f(x) over 20 bits as follows:
- fa(n) = bit n of 0x9E98.
- fb(n) = bit n of 0xB48E.
- f = bit i of 0xEC57E80A, where i = {fb(x[3:0]), fa(x[7:4]), fa(x[11:8]), fb(x[15:12]), fa(x[19:16])}, MSB first.
REQ-014 SHALL form ext_b = {b, cand} for b in {0,1}, with the new bit at the MSB, and test f(ext_b[W:W-19]) == ks.
REQ-015 SHALL use FSM states IDLE, TRY0 and TRY1; IN_READY SHALL be 1 only in IDLE.
REQ-016 On an input transfer in IDLE, SHALL latch CAND_IN, IN_LAST and KS_BIT into cand, last and ks, and go to TRY0 on the next cycle.
REQ-017 In TRYb on a match, SHALL hold OUT_VALID=1 with CAND_OUT=ext_b until an output transfer occurs, then advance.
REQ-018 In TRYb with no match, SHALL keep OUT_VALID=0 and advance after exactly one cycle.
REQ-019 SHALL advance TRY0 to TRY1, and TRY1 to IDLE.
REQ-020 SHALL keep CAND_OUT stable while OUT_VALID=1 and OUT_READY=0, and SHALL never deassert OUT_VALID before the transfer.
REQ-021 SHALL emit survivors in order ext_0 then ext_1, at most two per input candidate.
REQ-022 SHALL pulse DONE for the single cycle after leaving TRY1 with last=1, including when zero survivors were emitted.
REQ-023 SHALL increment SURV_CNT on each output transfer and saturate at 0xFFFF.
REQ-024 Latency: input transfer at edge N gives the earliest OUT_VALID in the cycle after edge N (the TRY0 cycle).
- Best throughput: one candidate per 3 cycles.
- Worst case with zero survivors: 3 cycles.
REQ-025 SHALL treat OUT_READY as a don't-care while OUT_VALID=0.

Reset
REQ-026 While RESET=1 at an edge, SHALL set:
- state to IDLE;
- OUT_VALID, DONE and SURV_CNT to 0;
- cand, last and ks to 0.
REQ-027 SHALL hold IN_READY=0 during the cycle RESET is asserted and drive IN_READY=1 the cycle after it deasserts.
REQ-028 SHALL let reset asserted mid-operation (TRY0/TRY1 with OUT_VALID pending) drop the pending survivor with no transfer and no DONE.

Verification
REQ-029 Bench SHALL drive W=20, CAND_IN=0x00000, KS_BIT=0, IN_LAST=1, OUT_READY=1.
- Required: CAND_OUT=0x000000 then 0x100000 on consecutive transfers.
- Required: DONE pulses once; SURV_CNT=2.
REQ-030 Bench SHALL drive CAND_IN=0x00000, KS_BIT=1, IN_LAST=1.
- Required: OUT_VALID never asserts.
- Required: DONE pulses in the cycle after leaving TRY1; SURV_CNT unchanged.
REQ-031 Bench SHALL drive CAND_IN=0xFFFFF, KS_BIT=1, with OUT_READY=0 for 5 cycles.
- Required: CAND_OUT=0x0FFFFF held stable and OUT_VALID=1 throughout.
- Required: then 0x1FFFFF after release; IN_READY=0 throughout.
REQ-032 Bench SHALL stream 100 random candidates against a reference model of f.
- Required: survivor set and order match the model exactly.
- Required: SURV_CNT equals the model count.
REQ-033 Bench SHALL assert RESET for 1 cycle while in TRY0 with OUT_VALID=1 and OUT_READY=0.
- Required: next cycle OUT_VALID=0, IN_READY=1, SURV_CNT=0; no DONE pulse.
REQ-034 Bench SHALL preload SURV_CNT to 0xFFFE via survivors, then emit 3 more.
- Required: SURV_CNT reads 0xFFFF and stays there.

Source files
------------

// File: rtl/key_extend.sv
// Key-extend stage: appends one bit to each candidate and forwards the
// extensions whose nonlinear filter output reproduces the keystream bit.
module key_extend #(
    parameter int unsigned W = 20
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] CAND_IN,
    input  logic         IN_LAST,
    input  logic         KS_BIT,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [W:0]   CAND_OUT,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic         DONE,
    output logic [15:0]  SURV_CNT
);

    localparam logic [15:0] FA_TAB = 16'h9E98;
    localparam logic [15:0] FB_TAB = 16'hB48E;
    localparam logic [31:0] FC_TAB = 32'hEC57E80A;

    typedef enum logic [1:0] {IDLE, TRY0, TRY1} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cand_q, cand_d;
    logic         last_q, last_d;
    logic         ks_q, ks_d;
    logic         done_q, done_d;
    logic [15:0]  surv_cnt_q, surv_cnt_d;

    logic         new_bit;
    logic [19:0]  f_in;
    logic         match;
    logic         out_xfer;

    function automatic logic filter_f(input logic [19:0] x);
        logic [4:0] idx;
        idx = {FB_TAB[x[3:0]], FA_TAB[x[7:4]], FA_TAB[x[11:8]],
               FB_TAB[x[15:12]], FA_TAB[x[19:16]]};
        return FC_TAB[idx];
    endfunction

    always_comb begin
        // The appended bit is the MSB, so the filter sees it plus the top 19 candidate bits.
        new_bit   = (state_q == TRY1);
        f_in      = {new_bit, cand_q[W-1 -: 19]};
        match     = (state_q != IDLE) && (filter_f(f_in) == ks_q);

        IN_READY  = (state_q == IDLE) && !RESET;
        OUT_VALID = match && !RESET;
        CAND_OUT  = {new_bit, cand_q};
        DONE      = done_q;
        SURV_CNT  = surv_cnt_q;
        out_xfer  = OUT_VALID && OUT_READY;

        state_d    = state_q;
        cand_d     = cand_q;
        last_d     = last_q;
        ks_d       = ks_q;
        done_d     = 1'b0;
        surv_cnt_d = surv_cnt_q;

        case (state_q)
            IDLE: begin
                if (IN_VALID && IN_READY) begin
                    cand_d  = CAND_IN;
                    last_d  = IN_LAST;
                    ks_d    = KS_BIT;
                    state_d = TRY0;
                end
            end
            TRY0: begin
                if (!match || out_xfer) state_d = TRY1;
            end
            TRY1: begin
                if (!match || out_xfer) begin
                    state_d = IDLE;
                    done_d  = last_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (out_xfer && (surv_cnt_q != 16'hFFFF)) surv_cnt_d = surv_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            last_q     <= 1'b0;
            ks_q       <= 1'b0;
            done_q     <= 1'b0;
            surv_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            last_q     <= last_d;
            ks_q       <= ks_d;
            done_q     <= done_d;
            surv_cnt_q <= surv_cnt_d;
        end
    end

endmodule
